// File: rtl/imuldiv_muldiv_dispatch.sv
// Mul/div front end: decodes unified requests, steers them to the iterative mul
// or div unit, and returns formatted results in strict request order.
module imuldiv_muldiv_dispatch #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [2:0]  muldivreq_msg_fn,
    input  logic [31:0] muldivreq_msg_a,
    input  logic [31:0] muldivreq_msg_b,
    input  logic        muldivreq_val,
    output logic        muldivreq_rdy,

    output logic [63:0] muldivresp_msg_result,
    output logic        muldivresp_val,
    input  logic        muldivresp_rdy,

    output logic [31:0] mulreq_msg_a,
    output logic [31:0] mulreq_msg_b,
    output logic        mulreq_val,
    input  logic        mulreq_rdy,
    input  logic [63:0] mulresp_msg_result,
    input  logic        mulresp_val,
    output logic        mulresp_rdy,

    output logic        divreq_msg_fn,
    output logic [31:0] divreq_msg_a,
    output logic [31:0] divreq_msg_b,
    output logic        divreq_val,
    input  logic        divreq_rdy,
    input  logic [63:0] divresp_msg_result,
    input  logic        divresp_val,
    output logic        divresp_rdy
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    localparam logic [2:0] FN_MUL  = 3'd0;
    localparam logic [2:0] FN_DIV  = 3'd1;
    localparam logic [2:0] FN_DIVU = 3'd2;
    localparam logic [2:0] FN_REM  = 3'd3;
    localparam logic [2:0] FN_REMU = 3'd4;

    // Div unit function encoding (matches the div request message macros)
    localparam logic DIV_SIGNED   = 1'b0;
    localparam logic DIV_UNSIGNED = 1'b1;

    typedef enum logic [1:0] {SEL_NULL, SEL_MUL, SEL_DIV} sel_t;

    function automatic sel_t unit_of(input logic [2:0] fn);
        case (fn)
            FN_MUL:                          return SEL_MUL;
            FN_DIV, FN_DIVU, FN_REM, FN_REMU: return SEL_DIV;
            default:                         return SEL_NULL;
        endcase
    endfunction

    logic [2:0]    fn_q [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          full, empty, accept, deq;
    sel_t          req_sel, head_sel;
    logic [2:0]    head_fn;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign req_sel  = unit_of(muldivreq_msg_fn);
    assign head_fn  = fn_q[rd_ptr];
    assign head_sel = unit_of(head_fn);

    assign mulreq_msg_a  = muldivreq_msg_a;
    assign mulreq_msg_b  = muldivreq_msg_b;
    assign divreq_msg_a  = muldivreq_msg_a;
    assign divreq_msg_b  = muldivreq_msg_b;
    assign divreq_msg_fn = (muldivreq_msg_fn == FN_DIVU || muldivreq_msg_fn == FN_REMU)
                           ? DIV_UNSIGNED : DIV_SIGNED;

    assign mulreq_val = muldivreq_val && !full && (req_sel == SEL_MUL);
    assign divreq_val = muldivreq_val && !full && (req_sel == SEL_DIV);

    always_comb begin
        muldivreq_rdy = 1'b0;
        if (!full) begin
            case (req_sel)
                SEL_MUL: muldivreq_rdy = mulreq_rdy;
                SEL_DIV: muldivreq_rdy = divreq_rdy;
                default: muldivreq_rdy = 1'b1;
            endcase
        end
    end

    assign accept = muldivreq_val && muldivreq_rdy;

    // Only the head entry's unit may hand back a response; the other unit stalls.
    always_comb begin
        muldivresp_val        = 1'b0;
        muldivresp_msg_result = '0;
        mulresp_rdy           = 1'b0;
        divresp_rdy           = 1'b0;
        if (!empty) begin
            case (head_sel)
                SEL_MUL: begin
                    muldivresp_val        = mulresp_val;
                    mulresp_rdy           = muldivresp_rdy;
                    muldivresp_msg_result = mulresp_msg_result;
                end
                SEL_DIV: begin
                    muldivresp_val = divresp_val;
                    divresp_rdy    = muldivresp_rdy;
                    if (head_fn == FN_REM || head_fn == FN_REMU)
                        muldivresp_msg_result = {32'b0, divresp_msg_result[63:32]};
                    else
                        muldivresp_msg_result = {32'b0, divresp_msg_result[31:0]};
                end
                default: muldivresp_val = 1'b1;
            endcase
        end
    end

    assign deq = muldivresp_val && muldivresp_rdy;

    always_ff @(posedge clk) begin
        if (accept) fn_q[wr_ptr] <= muldivreq_msg_fn;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (deq)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_imuldiv_muldiv_dispatch.sv
// Bench for imuldiv_muldiv_dispatch: behavioural mul/div unit stubs, an in-order
// result scoreboard checked every cycle, plus directed literal cases.
module tb_imuldiv_muldiv_dispatch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  muldivreq_msg_fn = '0;
    logic [31:0] muldivreq_msg_a = '0, muldivreq_msg_b = '0;
    logic        muldivreq_val = 1'b0;
    logic        muldivreq_rdy;
    logic [63:0] muldivresp_msg_result;
    logic        muldivresp_val;
    logic        muldivresp_rdy = 1'b0;
    logic [31:0] mulreq_msg_a, mulreq_msg_b;
    logic        mulreq_val;
    logic        mulreq_rdy = 1'b0;
    logic [63:0] mulresp_msg_result = '0;
    logic        mulresp_val = 1'b0;
    logic        mulresp_rdy;
    logic        divreq_msg_fn;
    logic [31:0] divreq_msg_a, divreq_msg_b;
    logic        divreq_val;
    logic        divreq_rdy = 1'b0;
    logic [63:0] divresp_msg_result = '0;
    logic        divresp_val = 1'b0;
    logic        divresp_rdy;

    always #5 clk = ~clk;

    imuldiv_muldiv_dispatch #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .muldivreq_msg_fn(muldivreq_msg_fn), .muldivreq_msg_a(muldivreq_msg_a),
        .muldivreq_msg_b(muldivreq_msg_b), .muldivreq_val(muldivreq_val),
        .muldivreq_rdy(muldivreq_rdy),
        .muldivresp_msg_result(muldivresp_msg_result), .muldivresp_val(muldivresp_val),
        .muldivresp_rdy(muldivresp_rdy),
        .mulreq_msg_a(mulreq_msg_a), .mulreq_msg_b(mulreq_msg_b), .mulreq_val(mulreq_val),
        .mulreq_rdy(mulreq_rdy), .mulresp_msg_result(mulresp_msg_result),
        .mulresp_val(mulresp_val), .mulresp_rdy(mulresp_rdy),
        .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
        .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
        .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val),
        .divresp_rdy(divresp_rdy)
    );

    int checks = 0;
    int failures = 0;

    logic [63:0] exp_q [$];
    logic [2:0]  expfn_q [$];
    logic [63:0] got_q [$];
    logic [63:0] mq [$];
    int          mt [$];
    logic [63:0] dq [$];
    int          dt [$];
    int          cyc = 0;
    int          mul_lat = 1, div_lat = 1;
    bit          unit_rand = 1'b0;
    int          rr_mode = 1;   // 0: resp_rdy low, 1: high, 2: random

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // What the combined stream must return for a request, from the function definitions.
    function automatic logic [63:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, sq, sr;
        logic [31:0] uq, ur;
        sa = a; sb = b;
        sq = sa / sb; sr = sa % sb;
        uq = a / b;   ur = a % b;
        case (f)
            3'd0:    return {32'b0, a} * {32'b0, b};
            3'd1:    return {32'b0, sq};
            3'd2:    return {32'b0, uq};
            3'd3:    return {32'b0, sr};
            3'd4:    return {32'b0, ur};
            default: return 64'h0;
        endcase
    endfunction

    // Iterative unit stand-in: {remainder, quotient}, signedness from the request fn bit.
    function automatic logic [63:0] div_unit(input logic fnbit, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, sq, sr;
        sa = a; sb = b;
        sq = sa / sb; sr = sa % sb;
        if (fnbit == 1'b0) return {sr, sq};
        return {a % b, a / b};
    endfunction

    // Handshake observation at the clock edge, then drive unit-side stimulus.
    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            exp_q.delete(); expfn_q.delete();
            mq.delete(); mt.delete(); dq.delete(); dt.delete();
        end else begin
            if (muldivreq_val && muldivreq_rdy) begin
                exp_q.push_back(model(muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b));
                expfn_q.push_back(muldivreq_msg_fn);
            end
            if (muldivresp_val && muldivresp_rdy) begin
                got_q.push_back(muldivresp_msg_result);
                if (exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    void'(expfn_q.pop_front());
                end
            end
            if (mulresp_val && mulresp_rdy && mq.size() > 0) begin
                void'(mq.pop_front()); void'(mt.pop_front());
            end
            if (divresp_val && divresp_rdy && dq.size() > 0) begin
                void'(dq.pop_front()); void'(dt.pop_front());
            end
            if (mulreq_val && mulreq_rdy) begin
                mq.push_back({32'b0, mulreq_msg_a} * {32'b0, mulreq_msg_b});
                mt.push_back(cyc + (unit_rand ? int'($urandom_range(1, 6)) : mul_lat));
            end
            if (divreq_val && divreq_rdy) begin
                dq.push_back(div_unit(divreq_msg_fn, divreq_msg_a, divreq_msg_b));
                dt.push_back(cyc + (unit_rand ? int'($urandom_range(1, 8)) : div_lat));
            end
        end
        #1;
        mulreq_rdy = unit_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        divreq_rdy = unit_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        mulresp_val = reset && (mq.size() > 0) && (mq.size() > 0 ? cyc >= mt[0] : 1'b0);
        mulresp_msg_result = (mq.size() > 0) ? mq[0] : 64'h0;
        divresp_val = reset && (dq.size() > 0) && (dq.size() > 0 ? cyc >= dt[0] : 1'b0);
        divresp_msg_result = (dq.size() > 0) ? dq[0] : 64'h0;
        muldivresp_rdy = (rr_mode == 2) ? ($urandom_range(0, 3) != 0) : (rr_mode == 1);
    end

    // Per-cycle comparison against the scoreboard, away from the active edge.
    always @(negedge clk) begin
        logic [2:0] f, hf;
        bit mfull, is_mul, is_div;
        if (!reset) begin
            chk("rst_resp_val", muldivresp_val, 0);
            chk("rst_mulresp_rdy", mulresp_rdy, 0);
            chk("rst_divresp_rdy", divresp_rdy, 0);
        end else begin
            f = muldivreq_msg_fn;
            mfull = exp_q.size() >= DEPTH;
            is_mul = (f == 3'd0);
            is_div = (f >= 3'd1 && f <= 3'd4);
            chk("req_rdy", muldivreq_rdy, !mfull && (is_mul ? mulreq_rdy : is_div ? divreq_rdy : 1'b1));
            chk("mulreq_val", mulreq_val, muldivreq_val && !mfull && is_mul);
            chk("divreq_val", divreq_val, muldivreq_val && !mfull && is_div);
            chk("operands", {mulreq_msg_a, divreq_msg_b}, {muldivreq_msg_a, muldivreq_msg_b});
            if (is_div) chk("divreq_fn", divreq_msg_fn, (f == 3'd2 || f == 3'd4));
            if (exp_q.size() == 0) begin
                chk("resp_val_empty", muldivresp_val, 0);
                chk("unit_rdy_empty", {mulresp_rdy, divresp_rdy}, 0);
            end else begin
                hf = expfn_q[0];
                chk("resp_val", muldivresp_val,
                    (hf == 3'd0) ? mulresp_val : (hf <= 3'd4) ? divresp_val : 1'b1);
                chk("mulresp_rdy", mulresp_rdy, (hf == 3'd0) && muldivresp_rdy);
                chk("divresp_rdy", divresp_rdy, (hf >= 3'd1 && hf <= 3'd4) && muldivresp_rdy);
                if (muldivresp_val) chk("resp_result", muldivresp_msg_result, exp_q[0]);
            end
        end
    end

    task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bit acc;
        int n;
        n = 0;
        muldivreq_msg_fn = f; muldivreq_msg_a = a; muldivreq_msg_b = b;
        muldivreq_val = 1'b1;
        forever begin
            @(negedge clk);
            acc = muldivreq_rdy;
            @(posedge clk); #1;
            if (acc) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        muldivreq_val = 1'b0;
    endtask

    task automatic wait_got(input int n, input string nm);
        int k;
        k = 0;
        while (got_q.size() < n && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        chk(nm, (got_q.size() >= n), 1);
    endtask

    task automatic set_rr(input int m);
        rr_mode = m;
        @(posedge clk); #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_mulreq_val", mulreq_val, 0);
        chk("reset_divreq_val", divreq_val, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_resp_val", muldivresp_val, 0);
        chk("post_reset_unit_rdys", {mulresp_rdy, divresp_rdy}, 0);
        @(posedge clk); #1;

        got_q.delete();
        send(3'd0, 32'd6, 32'd7);
        wait_got(1, "mul_wait");
        chk("mul_6x7", got_q[0], 64'd42);

        muldivreq_msg_fn = 3'd1; muldivreq_msg_a = 32'hFFFFFFF9; muldivreq_msg_b = 32'd2;
        @(negedge clk);
        chk("div_fn_signed", divreq_msg_fn, 1'b0);
        muldivreq_msg_fn = 3'd2;
        @(negedge clk);
        chk("divu_fn_unsigned", divreq_msg_fn, 1'b1);
        @(posedge clk); #1;
        got_q.delete();
        send(3'd1, 32'hFFFFFFF9, 32'd2);
        send(3'd3, 32'hFFFFFFF9, 32'd2);
        wait_got(2, "divrem_wait");
        chk("div_neg7_2", got_q[0], 64'h00000000_FFFFFFFD);
        chk("rem_neg7_2", got_q[1], 64'h00000000_FFFFFFFF);

        // Slow div ahead of a fast mul: mul response must wait its turn.
        mul_lat = 1; div_lat = 8;
        got_q.delete();
        send(3'd2, 32'd100, 32'd7);
        send(3'd0, 32'd3, 32'd5);
        repeat (2) @(negedge clk);
        chk("mul_held_behind_div", {mulresp_val, mulresp_rdy}, 2'b10);
        wait_got(2, "order_wait");
        chk("order_first_divu", got_q[0], 64'd14);
        chk("order_second_mul", got_q[1], 64'd15);
        div_lat = 1;

        // Fill with back-pressure, then drain and wrap.
        set_rr(0);
        for (int i = 1; i <= 4; i++) send(3'd0, 32'(i), 32'd10);
        muldivreq_msg_fn = 3'd0; muldivreq_msg_a = 32'd5; muldivreq_msg_b = 32'd10;
        muldivreq_val = 1'b1;
        @(negedge clk);
        chk("full_req_rdy", muldivreq_rdy, 0);
        chk("full_mulreq_val", mulreq_val, 0);
        @(posedge clk); #1;
        muldivreq_val = 1'b0;
        got_q.delete();
        set_rr(1);
        wait_got(4, "drain_wait");
        for (int i = 0; i < 4; i++) chk("drain_order", got_q[i], 64'(10 * (i + 1)));
        @(negedge clk);
        chk("drained_resp_val", muldivresp_val, 0);
        chk("drained_req_rdy", muldivreq_rdy, 1);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send(3'd0, 32'(i + 11), 32'd2);
        wait_got(8, "wrap_wait");
        for (int i = 0; i < 4; i++) chk("wrap_order", got_q[4 + i], 64'(2 * (i + 11)));

        // Illegal function: no unit touched, zero result the next cycle.
        got_q.delete();
        muldivreq_msg_fn = 3'd6; muldivreq_msg_a = 32'd1; muldivreq_msg_b = 32'd1;
        muldivreq_val = 1'b1;
        @(negedge clk);
        chk("null_unit_vals", {mulreq_val, divreq_val}, 2'b00);
        chk("null_req_rdy", muldivreq_rdy, 1);
        @(posedge clk); #1;
        muldivreq_val = 1'b0;
        @(negedge clk);
        chk("null_resp_val", muldivresp_val, 1);
        chk("null_resp_result", muldivresp_msg_result, 64'h0);
        @(posedge clk); #1;

        // Reset with entries outstanding.
        set_rr(0);
        for (int i = 0; i < 3; i++) send(3'd0, 32'd9, 32'(i + 1));
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("pre_reset_resp_val", muldivresp_val, 1);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("async_reset_resp_val", muldivresp_val, 0);
        chk("async_reset_mulresp_rdy", mulresp_rdy, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        rr_mode = 1;
        @(posedge clk); #2;
        got_q.delete();
        send(3'd4, 32'd10, 32'd3);
        wait_got(1, "remu_wait");
        chk("remu_10_3", got_q[0], 64'd1);

        // Randomized traffic against the scoreboard.
        unit_rand = 1'b1;
        set_rr(2);
        for (int i = 0; i < 400; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 20));
            if ($urandom_range(0, 3) == 0) a = -a;
            if (b == 32'd0) b = 32'd1;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
            send(f, a, b);
        end
        set_rr(1);
        begin
            int k;
            k = 0;
            while (exp_q.size() > 0 && k < 1000) begin
                @(posedge clk); #1;
                k++;
            end
        end
        chk("final_drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
